// File: rtl/zram_arbiter.sv
// Two-master arbiter for the single-port program/data RAM: CPU port C and debug/loader port D.
// Round-robin on ties; D may lock the RAM for bursts, bounded by a forced C slot after MAX_LOCK grants.
module zram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCKED_D = 2'd1,
    FORCE_C  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_d_r;
  logic        last_d_nxt_s;
  logic [7:0]  lock_cnt_r;
  logic [7:0]  lock_cnt_nxt_s;
  logic [7:0]  cnt_inc_s;
  logic        c_rvalid_r;
  logic        d_rvalid_r;
  logic        c_gnt_s;
  logic        d_gnt_s;

  // Saturating successor of the lock counter; it never wraps past MAX_CNT.
  assign cnt_inc_s = (lock_cnt_r >= MAX_CNT) ? MAX_CNT : (lock_cnt_r + 8'd1);

  // State register, round-robin pointer, lock counter and read-valid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ARB;
      last_d_r   <= 1'b1;
      lock_cnt_r <= 8'd0;
      c_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_d_r   <= last_d_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      c_rvalid_r <= c_gnt_s & ~c_we;
      d_rvalid_r <= d_gnt_s & ~d_we;
    end
  end

  // Next-state, lock counter and last-winner update.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    if (c_gnt_s) begin
      last_d_nxt_s = 1'b0;
    end else if (d_gnt_s) begin
      last_d_nxt_s = 1'b1;
    end else begin
      last_d_nxt_s = last_d_r;
    end
    case (state_r)
      ARB: begin
        if (d_gnt_s && d_lock) begin
          lock_cnt_nxt_s = 8'd1;
          if ((MAX_CNT == 8'd1) && c_req) begin
            state_nxt_s = FORCE_C;
          end else begin
            state_nxt_s = LOCKED_D;
          end
        end else begin
          lock_cnt_nxt_s = 8'd0;
          state_nxt_s    = ARB;
        end
      end
      LOCKED_D: begin
        // The grant that reaches MAX_CNT while C waits hands the next slot to C.
        if (d_gnt_s) begin
          lock_cnt_nxt_s = cnt_inc_s;
          if ((cnt_inc_s == MAX_CNT) && c_req) begin
            state_nxt_s = FORCE_C;
          end else begin
            state_nxt_s = LOCKED_D;
          end
        end else begin
          lock_cnt_nxt_s = 8'd0;
          state_nxt_s    = ARB;
        end
      end
      FORCE_C: begin
        lock_cnt_nxt_s = 8'd0;
        state_nxt_s    = ARB;
      end
      default: begin
        lock_cnt_nxt_s = 8'd0;
        state_nxt_s    = ARB;
      end
    endcase
  end

  // Grant decode; suppressed while reset is asserted.
  always_comb begin
    c_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst) begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          if (c_req && d_req) begin
            c_gnt_s = last_d_r;
            d_gnt_s = ~last_d_r;
          end else begin
            c_gnt_s = c_req;
            d_gnt_s = d_req;
          end
        end
        LOCKED_D: begin
          d_gnt_s = d_req & d_lock;
        end
        FORCE_C: begin
          c_gnt_s = c_req;
        end
        default: begin
          c_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // RAM command mux from the current winner.
  always_comb begin
    if (c_gnt_s) begin
      ram_addr  = c_addr;
      ram_we    = c_we;
      ram_wdata = c_wdata;
    end else if (d_gnt_s) begin
      ram_addr  = d_addr;
      ram_we    = d_we;
      ram_wdata = d_wdata;
    end else begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_we    = 1'b0;
      ram_wdata = {DATA_W{1'b0}};
    end
  end

  assign c_gnt    = c_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign c_rvalid = c_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign c_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_zram_arbiter.sv
// Directed bench for zram_arbiter with a small synchronous RAM model and MAX_LOCK=4.
module tb_zram_arbiter;

  logic       clk;
  logic       rst;
  logic       c_req, c_we, c_gnt, c_rvalid;
  logic [3:0] c_addr;
  logic [7:0] c_wdata, c_rdata;
  logic       d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [3:0] d_addr;
  logic [7:0] d_wdata, d_rdata;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] mem [16];
  logic [5:0] lk_c;

  int vec_cnt = 0;
  int err_cnt = 0;

  zram_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded while reset is held, 1-cycle synchronous read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
      mem[3] <= 8'h7F;
      mem[5] <= 8'h55;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_gnt(input string tag, input logic ec, input logic ed);
    check_value({tag, ".c_gnt"}, 32'(c_gnt), 32'(ec));
    check_value({tag, ".d_gnt"}, 32'(d_gnt), 32'(ed));
  endtask

  task automatic exp_rv(input string tag, input logic ec, input logic ed);
    check_value({tag, ".c_rvalid"}, 32'(c_rvalid), 32'(ec));
    check_value({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(ed));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'd3; c_wdata = 8'h00;
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd5; d_wdata = 8'hEE; d_lock = 1'b0;
    lk_c = 6'b010000;

    // reset holds grants, write enable and strobes low
    smp();
    exp_gnt("rst", 1'b0, 1'b0);
    exp_rv("rst", 1'b0, 1'b0);
    check_value("rst.ram_we", 32'(ram_we), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    d_we = 1'b0;

    // both reading continuously: C,D,C,D
    smp(); exp_gnt("alt1", 1'b1, 1'b0); exp_rv("alt1", 1'b0, 1'b0);
    check_value("alt1.ram_addr", 32'(ram_addr), 32'h3);
    cyc(); smp(); exp_gnt("alt2", 1'b0, 1'b1); exp_rv("alt2", 1'b1, 1'b0);
    check_value("alt2.c_rdata", 32'(c_rdata), 32'h7F);
    check_value("alt2.ram_addr", 32'(ram_addr), 32'h5);
    cyc(); smp(); exp_gnt("alt3", 1'b1, 1'b0); exp_rv("alt3", 1'b0, 1'b1);
    check_value("alt3.d_rdata", 32'(d_rdata), 32'h55);
    cyc(); smp(); exp_gnt("alt4", 1'b0, 1'b1); exp_rv("alt4", 1'b1, 1'b0);
    cyc(); c_req = 1'b0; d_req = 1'b0;
    smp(); exp_gnt("idle", 1'b0, 1'b0); exp_rv("idle", 1'b0, 1'b1);
    check_value("idle.ram_addr", 32'(ram_addr), 32'h0);
    check_value("idle.ram_we", 32'(ram_we), 32'h0);

    // C alone reads addr 3
    cyc(); c_req = 1'b1; c_addr = 4'd3;
    smp(); exp_gnt("crd", 1'b1, 1'b0);
    cyc(); c_req = 1'b0;
    smp(); exp_rv("crd.rv", 1'b1, 1'b0);
    check_value("crd.c_rdata", 32'(c_rdata), 32'h7F);

    // D writes AA to 9, C reads 9 next slot
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 4'd9; d_wdata = 8'hAA;
    smp(); exp_gnt("dwr", 1'b0, 1'b1); exp_rv("dwr", 1'b0, 1'b0);
    check_value("dwr.ram_we", 32'(ram_we), 32'h1);
    check_value("dwr.ram_addr", 32'(ram_addr), 32'h9);
    check_value("dwr.ram_wdata", 32'(ram_wdata), 32'hAA);
    cyc(); d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_addr = 4'd9;
    smp(); exp_gnt("wrd", 1'b1, 1'b0); exp_rv("wrd", 1'b0, 1'b0);
    cyc(); c_req = 1'b0;
    smp(); exp_rv("wrd.rv", 1'b1, 1'b0);
    check_value("wrd.c_rdata", 32'(c_rdata), 32'hAA);

    // lock burst with C waiting: D,D,D,D,C,D
    cyc(); c_req = 1'b1; c_addr = 4'd3; d_req = 1'b1; d_addr = 4'd5; d_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      exp_gnt($sformatf("lock%0d", i), lk_c[i], ~lk_c[i]);
      if (i == 5) begin
        exp_rv("lock5", 1'b1, 1'b0);
        check_value("lock5.c_rdata", 32'(c_rdata), 32'h7F);
      end
      cyc();
    end

    // C idle: D keeps the lock past saturation
    c_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp();
      exp_gnt($sformatf("sat%0d", i), 1'b0, 1'b1);
      cyc();
    end
    c_req = 1'b1;
    smp(); exp_gnt("crise", 1'b0, 1'b1);
    cyc(); smp(); exp_gnt("forcec", 1'b1, 1'b0);
    cyc(); smp(); exp_gnt("relock", 1'b0, 1'b1); exp_rv("relock", 1'b1, 1'b0);
    cyc(); smp(); exp_gnt("lkrd", 1'b0, 1'b1); exp_rv("lkrd", 1'b0, 1'b1);

    // reset mid-lock on a read grant cycle
    #1 rst = 1'b1;
    #1;
    exp_gnt("midrst", 1'b0, 1'b0);
    exp_rv("midrst", 1'b0, 1'b0);
    check_value("midrst.ram_we", 32'(ram_we), 32'h0);
    cyc(); rst = 1'b0; d_lock = 1'b0;
    smp(); exp_gnt("post", 1'b1, 1'b0); exp_rv("post", 1'b0, 1'b0);
    cyc(); smp(); exp_gnt("post2", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
